// File: rtl/pipe_ctrl_if.sv
// Pipeline control bundle: hazard/redirect requests in, stall/flush/redirect
// and performance counters out. The controller uses the slave side.
interface pipe_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int NSTAGE = 5,
  parameter int CNT_W  = 32
);
  logic              jump_en_i;
  logic [ADDR_W-1:0] jump_addr_i;
  logic [NSTAGE-1:0] hold_req_i;
  logic              jump_en_o;
  logic [ADDR_W-1:0] jump_addr_o;
  logic [NSTAGE-1:0] stall_o;
  logic [NSTAGE-1:0] flush_o;
  logic              hold_flag_o;
  logic [CNT_W-1:0]  stall_cycles_o;
  logic [CNT_W-1:0]  flush_cycles_o;

  // No valid/ready pairs here: every request is level-sensitive and is
  // answered combinationally in the same cycle it is presented.
  modport master (
    output jump_en_i, jump_addr_i, hold_req_i,
    input  jump_en_o, jump_addr_o, stall_o, flush_o, hold_flag_o,
           stall_cycles_o, flush_cycles_o
  );

  modport slave (
    input  jump_en_i, jump_addr_i, hold_req_i,
    output jump_en_o, jump_addr_o, stall_o, flush_o, hold_flag_o,
           stall_cycles_o, flush_cycles_o
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline hazard/redirect controller: decodes per-stage holds into stall and
// bubble vectors, defers blocked redirects, and flushes fetch after a redirect.
module pipe_ctrl #(
  parameter int ADDR_W     = 32,
  parameter int NSTAGE     = 5,
  parameter int JUMP_STAGE = 2,
  parameter int FETCH_LAT  = 1,
  parameter int CNT_W      = 32
) (
  input  logic        clk,
  input  logic        rst,
  pipe_ctrl_if.slave  bus
);

  localparam logic [2:0]        FL_INIT  = 3'(FETCH_LAT);
  localparam logic [NSTAGE-1:0] IFID_BIT = NSTAGE'(2);
  localparam logic [NSTAGE-1:0] PC_BIT   = NSTAGE'(1);

  logic              pend_vld_q, pend_vld_d;
  logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
  logic [2:0]        fl_cnt_q, fl_cnt_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

  logic [NSTAGE-1:0] hold_stall, hold_flush, jump_mask;
  logic [NSTAGE-1:0] stall, flush;
  logic              above;
  logic              src_vld, blocked, taken;
  logic [ADDR_W-1:0] src_addr;

  // hold_stall[j] is set when any hold at or above j exists (j <= k);
  // the bubble goes into the register just above the highest hold.
  always_comb begin
    hold_stall = '0;
    hold_flush = '0;
    above      = 1'b0;
    for (int j = NSTAGE - 1; j >= 0; j--) begin
      above         = above | bus.hold_req_i[j];
      hold_stall[j] = above;
    end
    for (int j = 1; j < NSTAGE; j++) begin
      hold_flush[j] = bus.hold_req_i[j-1] & ~hold_stall[j];
    end
  end

  always_comb begin
    jump_mask = '0;
    for (int j = 1; j <= JUMP_STAGE; j++) begin
      jump_mask[j] = 1'b1;
    end
  end

  assign src_vld  = pend_vld_q | bus.jump_en_i;
  assign src_addr = pend_vld_q ? pend_addr_q : bus.jump_addr_i;
  assign blocked  = src_vld & (|bus.hold_req_i[NSTAGE-1:JUMP_STAGE]);
  assign taken    = src_vld & ~blocked;

  always_comb begin
    flush = hold_flush;
    if (taken)          flush = flush | jump_mask;
    if (fl_cnt_q != '0) flush = flush | IFID_BIT;
    stall = hold_stall;
    if (taken)          stall = stall & ~(jump_mask | PC_BIT);
    stall = stall & ~flush;
  end

  always_comb begin
    pend_vld_d  = pend_vld_q;
    pend_addr_d = pend_addr_q;
    fl_cnt_d    = fl_cnt_q;
    if (fl_cnt_q != '0) fl_cnt_d = fl_cnt_q - 3'd1;
    if (blocked) begin
      pend_vld_d  = 1'b1;
      pend_addr_d = src_addr;
    end
    if (taken) begin
      pend_vld_d = 1'b0;
      fl_cnt_d   = FL_INIT;
    end
    stall_cnt_d = stall_cnt_q;
    if (stall[0] && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    flush_cnt_d = flush_cnt_q;
    if ((|flush) && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_vld_q  <= 1'b0;
      pend_addr_q <= '0;
      fl_cnt_q    <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      pend_vld_q  <= pend_vld_d;
      pend_addr_q <= pend_addr_d;
      fl_cnt_q    <= fl_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.jump_en_o      = taken;
  assign bus.jump_addr_o    = taken ? src_addr : '0;
  assign bus.stall_o        = stall;
  assign bus.flush_o        = flush;
  assign bus.hold_flag_o    = (|stall) | (|flush);
  assign bus.stall_cycles_o = stall_cnt_q;
  assign bus.flush_cycles_o = flush_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed scenarios followed by random traffic, checked
// cycle by cycle against a rule-level model of the controller.
module tb_pipe_ctrl;
  localparam int ADDR_W = 32;
  localparam int NS     = 5;
  localparam int JS     = 2;
  localparam int FL     = 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipe_ctrl_if #(.ADDR_W(ADDR_W), .NSTAGE(NS), .CNT_W(32)) bus ();
  pipe_ctrl_if #(.ADDR_W(ADDR_W), .NSTAGE(NS), .CNT_W(4))  bus4 ();

  pipe_ctrl #(.ADDR_W(ADDR_W), .NSTAGE(NS), .JUMP_STAGE(JS), .FETCH_LAT(FL), .CNT_W(32))
    dut (.clk(clk), .rst(rst), .bus(bus.slave));
  pipe_ctrl #(.ADDR_W(ADDR_W), .NSTAGE(NS), .JUMP_STAGE(JS), .FETCH_LAT(FL), .CNT_W(4))
    dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));

  int tests = 0;
  int fails = 0;

  // Model state
  bit          m_pend;
  logic [31:0] m_paddr;
  int          m_win;
  longint      m_sc, m_fc, m_sc4, m_fc4;

  // Current stimulus
  bit          in_jen;
  logic [31:0] in_jaddr;
  logic [4:0]  in_hold;

  // Expected outputs and next model state
  bit          e_jen;
  logic [31:0] e_jaddr;
  logic [4:0]  e_stall, e_flush;
  bit          n_pend;
  logic [31:0] n_paddr;
  int          n_win;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pend = 0; m_paddr = 0; m_win = 0;
    m_sc = 0; m_fc = 0; m_sc4 = 0; m_fc4 = 0;
  endtask

  task automatic drive(input bit jen, input logic [31:0] addr, input logic [4:0] hold);
    in_jen = jen; in_jaddr = addr; in_hold = hold;
    bus.jump_en_i  = jen;  bus.jump_addr_i  = addr;  bus.hold_req_i  = hold;
    bus4.jump_en_i = jen;  bus4.jump_addr_i = addr;  bus4.hold_req_i = hold;
  endtask

  task automatic compute();
    int k;
    bit src_vld, blk, tkn;
    logic [31:0] src_addr;
    int st, fl;
    k = -1;
    for (int i = 0; i < NS; i++) if (in_hold[i]) k = i;
    st = (k >= 0) ? ((1 << (k + 1)) - 1) : 0;
    fl = (k >= 0 && k + 1 < NS) ? (1 << (k + 1)) : 0;
    src_vld  = m_pend || in_jen;
    src_addr = m_pend ? m_paddr : in_jaddr;
    blk = src_vld && (k >= JS);
    tkn = src_vld && !blk;
    n_pend = m_pend; n_paddr = m_paddr;
    n_win  = (m_win > 0) ? m_win - 1 : 0;
    if (tkn) begin
      for (int j = 1; j <= JS; j++) fl = fl | (1 << j);
      for (int j = 0; j <= JS; j++) st = st & ~(1 << j);
      n_pend = 0;
      n_win  = FL;
    end
    if (blk) begin
      n_pend = 1; n_paddr = src_addr;
    end
    if (m_win > 0) fl = fl | 2;
    st = st & ~fl;
    e_stall = st[4:0];
    e_flush = fl[4:0];
    e_jen   = tkn;
    e_jaddr = tkn ? src_addr : 32'h0;
  endtask

  task automatic check_all(input string tag);
    compute();
    chk({tag, ".jump_en"},   bus.jump_en_o,   e_jen);
    chk({tag, ".jump_addr"}, bus.jump_addr_o, e_jaddr);
    chk({tag, ".stall"},     bus.stall_o,     e_stall);
    chk({tag, ".flush"},     bus.flush_o,     e_flush);
    chk({tag, ".hold_flag"}, bus.hold_flag_o, (e_stall != 0) || (e_flush != 0));
    chk({tag, ".stall_cnt"}, bus.stall_cycles_o, m_sc);
    chk({tag, ".flush_cnt"}, bus.flush_cycles_o, m_fc);
    chk({tag, ".stall_cnt4"}, bus4.stall_cycles_o, m_sc4);
    chk({tag, ".flush_cnt4"}, bus4.flush_cycles_o, m_fc4);
  endtask

  // Advance one clock; model state follows the DUT edge.
  task automatic tick();
    compute();
    @(posedge clk);
    m_pend = n_pend; m_paddr = n_paddr; m_win = n_win;
    if (e_stall[0]) begin
      if (m_sc < 64'hFFFF_FFFF) m_sc++;
      if (m_sc4 < 15) m_sc4++;
    end
    if (e_flush != 0) begin
      if (m_fc < 64'hFFFF_FFFF) m_fc++;
      if (m_fc4 < 15) m_fc4++;
    end
    @(negedge clk);
  endtask

  task automatic step(input string tag, input bit jen, input logic [31:0] addr,
                      input logic [4:0] hold);
    drive(jen, addr, hold);
    #1;
    check_all(tag);
    tick();
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 0);
    model_reset();
    #1;
    check_all("reset");
    chk("reset.zero_stall", bus.stall_o, 5'b0);
    @(negedge clk);
    rst = 1'b0;

    // Load-use hold
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 5'b00010);
      #1;
      check_all("loaduse");
      chk("loaduse.stall_const", bus.stall_o, 5'b00011);
      chk("loaduse.flush_const", bus.flush_o, 5'b00100);
      tick();
    end

    // Unobstructed redirect then fetch window
    drive(1, 32'h100, 0);
    #1;
    check_all("jump");
    chk("jump.flush_const", bus.flush_o, 5'b00110);
    chk("jump.addr_const", bus.jump_addr_o, 32'h100);
    tick();
    drive(0, 0, 0);
    #1;
    check_all("window");
    chk("window.flush_const", bus.flush_o, 5'b00010);
    tick();
    drive(0, 0, 0);
    #1;
    chk("window_end.flush_const", bus.flush_o, 5'b00000);
    check_all("window_end");
    tick();

    // Redirect blocked by a memory-stage hold, released later
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'h200, 5'b01000);
      #1;
      check_all("blocked");
      chk("blocked.stall_const", bus.stall_o, 5'b01111);
      tick();
    end
    drive(0, 0, 0);
    #1;
    check_all("release");
    chk("release.addr_const", bus.jump_addr_o, 32'h200);
    tick();
    step("after_release", 0, 0, 0);

    // Pending redirect wins over same-cycle new jump
    step("pend300", 1, 32'h300, 5'b10000);
    drive(1, 32'h400, 0);
    #1;
    check_all("pend_wins");
    chk("pend_wins.addr_const", bus.jump_addr_o, 32'h300);
    tick();
    step("idle_a", 0, 0, 0);
    step("idle_b", 0, 0, 0);

    // Asynchronous reset drops a pending redirect
    step("pend500", 1, 32'h500, 5'b00100);
    drive(0, 0, 0);
    #1;
    check_all("pre_rst");
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check_all("async_rst");
    @(negedge clk);
    rst = 1'b0;
    step("post_rst", 0, 0, 0);

    // Counter saturation on the narrow instance
    for (int i = 0; i < 20; i++) step("sat", 0, 0, 5'b00001);
    chk("sat.stall_cnt4_max", bus4.stall_cycles_o, 4'hF);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      logic [4:0] h;
      h = ($urandom_range(0, 2) == 0) ? 5'($urandom_range(0, 31)) : 5'b0;
      step("rand", ($urandom_range(0, 3) == 0), $urandom, h);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
